// File: rtl/core_mem_arbiter.sv
// -----------------------------------------------------------------------------
// core_mem_arbiter
//
// Two-port arbiter in front of a single-outstanding memory interface.
// Port 0 is the core data port and port 1 is the loader/DMA port. One
// transaction is in flight at a time. Ports that request together are
// served round-robin.
//
// Handshake: a requester holds req/addr/wr/wdata/be stable until it sees
// its one-cycle gnt. Every grant gets exactly one rvalid, one or more
// cycles later, unless the memory response times out. On a timeout err
// pulses and the requester gets no rvalid.
//
// Parameters
//   ADDR_WIDTH  memory byte-address width
//   DATA_WIDTH  data bus width
//   BE_WIDTH    byte-enable width (DATA_WIDTH/8)
//   TIMEOUT     cycles to wait for mem_rvalid_i after a grant (1..255)
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   pN_req_i / pN_addr_i /     requester N transaction request and fields
//   pN_wr_i / pN_wdata_i /
//   pN_be_i
//   pN_gnt_o                   one-cycle grant to requester N
//   pN_rvalid_o, pN_rdata_o    response to requester N (rdata 0 otherwise)
//   mem_req_o ... mem_be_o     request to memory (fields 0 when idle)
//   mem_gnt_i                  memory accepted the request this cycle
//   mem_rvalid_i, mem_rdata_i  memory response (reads and writes)
//   err_o                      one-cycle pulse on response timeout
// -----------------------------------------------------------------------------
module core_mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  p0_req_i,
    input  logic [ADDR_WIDTH-1:0] p0_addr_i,
    input  logic                  p0_wr_i,
    input  logic [DATA_WIDTH-1:0] p0_wdata_i,
    input  logic [BE_WIDTH-1:0]   p0_be_i,
    output logic                  p0_gnt_o,
    output logic                  p0_rvalid_o,
    output logic [DATA_WIDTH-1:0] p0_rdata_o,

    input  logic                  p1_req_i,
    input  logic [ADDR_WIDTH-1:0] p1_addr_i,
    input  logic                  p1_wr_i,
    input  logic [DATA_WIDTH-1:0] p1_wdata_i,
    input  logic [BE_WIDTH-1:0]   p1_be_i,
    output logic                  p1_gnt_o,
    output logic                  p1_rvalid_o,
    output logic [DATA_WIDTH-1:0] p1_rdata_o,

    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_wr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [BE_WIDTH-1:0]   mem_be_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,

    output logic                  err_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT_RV = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state_q;
    logic       owner_q;   // port that owns the current transaction
    logic       prio_q;    // port favoured when both request (0 or 1)
    logic [7:0] cnt_q;     // cycles spent in WAIT_RV without a response
    logic       err_q;

    logic       any_req;
    logic       sel;       // combinational winner while idle
    logic       cur_owner; // port whose fields are presented this cycle
    logic       mem_req;
    logic       take;      // memory accepts the presented request
    logic       rv_hit;    // response belongs to the outstanding transaction
    logic [7:0] cnt_inc;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign any_req = p0_req_i | p1_req_i;

    // With both requesting the pointer decides. Otherwise the sole
    // requester wins. With no requester sel is 0, but it goes unused.
    assign sel = (p0_req_i & p1_req_i) ? prio_q : p1_req_i;

    // While idle the winner is picked combinationally. Once the arbiter
    // leaves IDLE, the latched owner is used and is not re-arbitrated.
    assign cur_owner = (state_q == ST_IDLE) ? sel : owner_q;

    // rst_n gates the request so that a requester holding req while the
    // arbiter is in reset cannot reach the memory.
    assign mem_req = rst_n &
                     (((state_q == ST_IDLE) & any_req) | (state_q == ST_REQ));

    assign take = mem_req & mem_gnt_i;

    // ------------------------------------------------------------------
    // Memory-side outputs: fields are forced to zero when no request is
    // being presented.
    // ------------------------------------------------------------------
    always_comb begin
        mem_req_o   = mem_req;
        mem_addr_o  = '0;
        mem_wr_o    = 1'b0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (mem_req) begin
            if (cur_owner) begin
                mem_addr_o  = p1_addr_i;
                mem_wr_o    = p1_wr_i;
                mem_wdata_o = p1_wdata_i;
                mem_be_o    = p1_be_i;
            end else begin
                mem_addr_o  = p0_addr_i;
                mem_wr_o    = p0_wr_i;
                mem_wdata_o = p0_wdata_i;
                mem_be_o    = p0_be_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Requester-side outputs
    // ------------------------------------------------------------------
    assign p0_gnt_o = take & ~cur_owner;
    assign p1_gnt_o = take &  cur_owner;

    // mem_rvalid_i counts only while a transaction is outstanding. Stray
    // or late pulses in any other state are dropped.
    assign rv_hit = rst_n & mem_rvalid_i & (state_q == ST_WAIT_RV);

    assign p0_rvalid_o = rv_hit & ~owner_q;
    assign p1_rvalid_o = rv_hit &  owner_q;
    assign p0_rdata_o  = p0_rvalid_o ? mem_rdata_i : '0;
    assign p1_rdata_o  = p1_rvalid_o ? mem_rdata_i : '0;

    assign err_o = err_q;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    assign cnt_inc = cnt_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        owner_q <= sel;
                        if (take) begin
                            state_q <= ST_WAIT_RV;
                            cnt_q   <= 8'd0;
                            prio_q  <= ~sel;
                        end else begin
                            state_q <= ST_REQ;
                        end
                    end
                end

                ST_REQ: begin
                    if (take) begin
                        state_q <= ST_WAIT_RV;
                        cnt_q   <= 8'd0;
                        prio_q  <= ~owner_q;
                    end
                end

                ST_WAIT_RV: begin
                    // A response that arrives in the last allowed cycle
                    // takes priority over the timeout.
                    if (mem_rvalid_i) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= 8'd0;
                    end else if (cnt_inc == TIMEOUT_CNT) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= 8'd0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_core_mem_arbiter
//
// Directed, cycle-by-cycle bench for core_mem_arbiter (TIMEOUT = 4).
// A table of per-cycle records gives the inputs and the expected outputs.
// Hand-written sequences then cover the response timeout, an rvalid on the
// timeout boundary, and reset during an outstanding transaction.
// -----------------------------------------------------------------------------
module tb_core_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int BW = 4;

    logic          clk;
    logic          rst_n;
    logic          p0_req, p1_req;
    logic [AW-1:0] p0_addr, p1_addr;
    logic          p0_wr, p1_wr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic [BW-1:0] p0_be, p1_be;
    logic          p0_gnt, p1_gnt;
    logic          p0_rvalid, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_wr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    core_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_i(p0_req), .p0_addr_i(p0_addr), .p0_wr_i(p0_wr),
        .p0_wdata_i(p0_wdata), .p0_be_i(p0_be),
        .p0_gnt_o(p0_gnt), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
        .p1_req_i(p1_req), .p1_addr_i(p1_addr), .p1_wr_i(p1_wr),
        .p1_wdata_i(p1_wdata), .p1_be_i(p1_be),
        .p1_gnt_o(p1_gnt), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_wr_o(mem_wr),
        .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .err_o(err)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic          p0_req; logic [AW-1:0] p0_addr; logic p0_wr;
        logic [DW-1:0] p0_wdata; logic [BW-1:0] p0_be;
        logic          p1_req; logic [AW-1:0] p1_addr; logic p1_wr;
        logic [DW-1:0] p1_wdata; logic [BW-1:0] p1_be;
        logic          gnt; logic rv; logic [DW-1:0] rdata;
        logic          e_req; logic [AW-1:0] e_addr; logic e_wr;
        logic [DW-1:0] e_wdata; logic [BW-1:0] e_be;
        logic          e_g0; logic e_g1;
        logic          e_v0; logic [DW-1:0] e_d0;
        logic          e_v1; logic [DW-1:0] e_d1;
        logic          e_err;
    } vec_t;

    localparam int NVEC = 28;
    vec_t vecs [NVEC];

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(
        input logic a_req, input logic [AW-1:0] a_addr, input logic a_wr,
        input logic [DW-1:0] a_wdata, input logic [BW-1:0] a_be,
        input logic b_req, input logic [AW-1:0] b_addr, input logic b_wr,
        input logic [DW-1:0] b_wdata, input logic [BW-1:0] b_be,
        input logic g, input logic rv, input logic [DW-1:0] rd);
        p0_req = a_req; p0_addr = a_addr; p0_wr = a_wr; p0_wdata = a_wdata; p0_be = a_be;
        p1_req = b_req; p1_addr = b_addr; p1_wr = b_wr; p1_wdata = b_wdata; p1_be = b_be;
        mem_gnt = g; mem_rvalid = rv; mem_rdata = rd;
    endtask

    task automatic drive_idle(input logic rv, input logic [DW-1:0] rd);
        drive(1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b0, 16'h0, 1'b0, 32'h0, 4'h0,
              1'b0, rv, rd);
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag,
        input logic e_req, input logic [AW-1:0] e_addr, input logic e_wr,
        input logic [DW-1:0] e_wdata, input logic [BW-1:0] e_be,
        input logic e_g0, input logic e_g1,
        input logic e_v0, input logic [DW-1:0] e_d0,
        input logic e_v1, input logic [DW-1:0] e_d1,
        input logic e_err);
        chk({tag, ".mem_req"},   32'(mem_req),   32'(e_req));
        chk({tag, ".mem_addr"},  32'(mem_addr),  32'(e_addr));
        chk({tag, ".mem_wr"},    32'(mem_wr),    32'(e_wr));
        chk({tag, ".mem_wdata"}, mem_wdata,      e_wdata);
        chk({tag, ".mem_be"},    32'(mem_be),    32'(e_be));
        chk({tag, ".p0_gnt"},    32'(p0_gnt),    32'(e_g0));
        chk({tag, ".p1_gnt"},    32'(p1_gnt),    32'(e_g1));
        chk({tag, ".p0_rvalid"}, 32'(p0_rvalid), 32'(e_v0));
        chk({tag, ".p0_rdata"},  p0_rdata,       e_d0);
        chk({tag, ".p1_rvalid"}, 32'(p1_rvalid), 32'(e_v1));
        chk({tag, ".p1_rdata"},  p1_rdata,       e_d1);
        chk({tag, ".err"},       32'(err),       32'(e_err));
    endtask

    task automatic check_zero(input string tag, input logic e_err);
        check_all(tag, 1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0,
                  1'b0, 32'h0, 1'b0, 32'h0, e_err);
    endtask

    // ---------------- test ----------------
    initial begin
        // p0 fields | p1 fields | gnt rv rdata || expected mem fields | g0 g1 | v0 d0 v1 d1 | err
        // Both request from reset: p0 first, p1 right after p0's rvalid.
        vecs[0]  = '{1'b1,16'h0010,1'b0,32'h11111111,4'hF, 1'b1,16'h0020,1'b1,32'hAAAA5555,4'h3, 1'b1,1'b0,32'h0,
                     1'b1,16'h0010,1'b0,32'h11111111,4'hF, 1'b1,1'b0, 1'b0,32'h0,1'b0,32'h0, 1'b0};
        vecs[1]  = '{1'b0,16'h0,1'b0,32'h0,4'h0, 1'b1,16'h0020,1'b1,32'hAAAA5555,4'h3, 1'b0,1'b0,32'h0,
                     1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,1'b0, 1'b0,32'h0,1'b0,32'h0, 1'b0};
        vecs[2]  = '{1'b0,16'h0,1'b0,32'h0,4'h0, 1'b1,16'h0020,1'b1,32'hAAAA5555,4'h3, 1'b0,1'b1,32'h0BADF00D,
                     1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,1'b0, 1'b1,32'h0BADF00D,1'b0,32'h0, 1'b0};
        vecs[3]  = '{1'b0,16'h0,1'b0,32'h0,4'h0, 1'b1,16'h0020,1'b1,32'hAAAA5555,4'h3, 1'b1,1'b0,32'h0,
                     1'b1,16'h0020,1'b1,32'hAAAA5555,4'h3, 1'b0,1'b1, 1'b0,32'h0,1'b0,32'h0, 1'b0};
        vecs[4]  = '{1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,1'b1,32'h55AA55AA,
                     1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,1'b0, 1'b0,32'h0,1'b1,32'h55AA55AA, 1'b0};
        // p1 write with grant delayed 3 cycles; p0 requests meanwhile, but owner stays p1.
        vecs[5]  = '{1'b0,16'h0,1'b0,32'h0,4'h0, 1'b1,16'h0100,1'b1,32'h12345678,4'hF, 1'b0,1'b0,32'h0,
                     1'b1,16'h0100,1'b1,32'h12345678,4'hF, 1'b0,1'b0, 1'b0,32'h0,1'b0,32'h0, 1'b0};
        vecs[6]  = '{1'b1,16'h0050,1'b1,32'hCAFE0000,4'hC, 1'b1,16'h0100,1'b1,32'h12345678,4'hF, 1'b0,1'b0,32'h0,
                     1'b1,16'h0100,1'b1,32'h12345678,4'hF, 1'b0,1'b0, 1'b0,32'h0,1'b0,32'h0, 1'b0};
        vecs[7]  = vecs[6];
        vecs[8]  = '{1'b1,16'h0050,1'b1,32'hCAFE0000,4'hC, 1'b1,16'h0100,1'b1,32'h12345678,4'hF, 1'b1,1'b0,32'h0,
                     1'b1,16'h0100,1'b1,32'h12345678,4'hF, 1'b0,1'b1, 1'b0,32'h0,1'b0,32'h0, 1'b0};
        vecs[9]  = '{1'b1,16'h0050,1'b1,32'hCAFE0000,4'hC, 1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,1'b0,32'h0,
                     1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,1'b0, 1'b0,32'h0,1'b0,32'h0, 1'b0};
        vecs[10] = '{1'b1,16'h0050,1'b1,32'hCAFE0000,4'hC, 1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,1'b1,32'h9ABCDEF0,
                     1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,1'b0, 1'b0,32'h0,1'b1,32'h9ABCDEF0, 1'b0};
        vecs[11] = '{1'b1,16'h0050,1'b1,32'hCAFE0000,4'hC, 1'b0,16'h0,1'b0,32'h0,4'h0, 1'b1,1'b0,32'h0,
                     1'b1,16'h0050,1'b1,32'hCAFE0000,4'hC, 1'b1,1'b0, 1'b0,32'h0,1'b0,32'h0, 1'b0};
        vecs[12] = '{1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,1'b1,32'h13579BDF,
                     1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,1'b0, 1'b1,32'h13579BDF,1'b0,32'h0, 1'b0};
        // Round-robin: pointer favours p1 after p0's grant, then p0 again.
        vecs[13] = '{1'b1,16'h0060,1'b0,32'h0,4'hF, 1'b1,16'h0070,1'b0,32'h0,4'h1, 1'b1,1'b0,32'h0,
                     1'b1,16'h0070,1'b0,32'h0,4'h1, 1'b0,1'b1, 1'b0,32'h0,1'b0,32'h0, 1'b0};
        vecs[14] = '{1'b1,16'h0060,1'b0,32'h0,4'hF, 1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,1'b1,32'h2468ACE0,
                     1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,1'b0, 1'b0,32'h0,1'b1,32'h2468ACE0, 1'b0};
        vecs[15] = '{1'b1,16'h0060,1'b0,32'h0,4'hF, 1'b1,16'h0070,1'b0,32'h0,4'h1, 1'b1,1'b0,32'h0,
                     1'b1,16'h0060,1'b0,32'h0,4'hF, 1'b1,1'b0, 1'b0,32'h0,1'b0,32'h0, 1'b0};
        vecs[16] = '{1'b0,16'h0,1'b0,32'h0,4'h0, 1'b1,16'h0070,1'b0,32'h0,4'h1, 1'b0,1'b1,32'h0F0F0F0F,
                     1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,1'b0, 1'b1,32'h0F0F0F0F,1'b0,32'h0, 1'b0};
        vecs[17] = '{1'b0,16'h0,1'b0,32'h0,4'h0, 1'b1,16'h0070,1'b0,32'h0,4'h1, 1'b1,1'b0,32'h0,
                     1'b1,16'h0070,1'b0,32'h0,4'h1, 1'b0,1'b1, 1'b0,32'h0,1'b0,32'h0, 1'b0};
        vecs[18] = '{1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,1'b1,32'h77778888,
                     1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,1'b0, 1'b0,32'h0,1'b1,32'h77778888, 1'b0};
        // p0 read 0x0040, immediate grant, rvalid two cycles later.
        vecs[19] = '{1'b1,16'h0040,1'b0,32'h0,4'hF, 1'b0,16'h0,1'b0,32'h0,4'h0, 1'b1,1'b0,32'h0,
                     1'b1,16'h0040,1'b0,32'h0,4'hF, 1'b1,1'b0, 1'b0,32'h0,1'b0,32'h0, 1'b0};
        vecs[20] = '{1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,1'b0,32'h0,
                     1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,1'b0, 1'b0,32'h0,1'b0,32'h0, 1'b0};
        vecs[21] = '{1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,1'b1,32'hDEADBEEF,
                     1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,1'b0, 1'b1,32'hDEADBEEF,1'b0,32'h0, 1'b0};
        // Stray rvalid while idle is ignored; the next request is taken at once.
        vecs[22] = '{1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,1'b1,32'hCAFEF00D,
                     1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,1'b0, 1'b0,32'h0,1'b0,32'h0, 1'b0};
        vecs[23] = '{1'b0,16'h0,1'b0,32'h0,4'h0, 1'b1,16'h0200,1'b0,32'h0,4'h1, 1'b1,1'b0,32'h0,
                     1'b1,16'h0200,1'b0,32'h0,4'h1, 1'b0,1'b1, 1'b0,32'h0,1'b0,32'h0, 1'b0};
        vecs[24] = '{1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,1'b1,32'h76543210,
                     1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,1'b0, 1'b0,32'h0,1'b1,32'h76543210, 1'b0};
        // Sole requester p1 wins although the pointer favours p0.
        vecs[25] = '{1'b0,16'h0,1'b0,32'h0,4'h0, 1'b1,16'h0204,1'b0,32'h0,4'h2, 1'b0,1'b0,32'h0,
                     1'b1,16'h0204,1'b0,32'h0,4'h2, 1'b0,1'b0, 1'b0,32'h0,1'b0,32'h0, 1'b0};
        vecs[26] = '{1'b0,16'h0,1'b0,32'h0,4'h0, 1'b1,16'h0204,1'b0,32'h0,4'h2, 1'b1,1'b0,32'h0,
                     1'b1,16'h0204,1'b0,32'h0,4'h2, 1'b0,1'b1, 1'b0,32'h0,1'b0,32'h0, 1'b0};
        vecs[27] = '{1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,1'b1,32'h31415926,
                     1'b0,16'h0,1'b0,32'h0,4'h0, 1'b0,1'b0, 1'b0,32'h0,1'b1,32'h31415926, 1'b0};

        // ---- reset state ----
        rst_n = 1'b0;
        drive_idle(1'b0, 32'h0);
        #3;
        check_zero("reset_idle", 1'b0);
        // Active inputs while held in reset must not leak through.
        drive(1'b1, 16'h1234, 1'b1, 32'hFFFFFFFF, 4'hF, 1'b1, 16'h4321, 1'b1, 32'hFFFFFFFF, 4'hF,
              1'b1, 1'b1, 32'hFFFFFFFF);
        #1;
        check_zero("reset_busy", 1'b0);
        tick();
        tick();
        drive_idle(1'b0, 32'h0);
        rst_n = 1'b1;
        tick();

        // ---- table ----
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].p0_req, vecs[i].p0_addr, vecs[i].p0_wr, vecs[i].p0_wdata, vecs[i].p0_be,
                  vecs[i].p1_req, vecs[i].p1_addr, vecs[i].p1_wr, vecs[i].p1_wdata, vecs[i].p1_be,
                  vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
            #2;
            check_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_wr,
                      vecs[i].e_wdata, vecs[i].e_be, vecs[i].e_g0, vecs[i].e_g1,
                      vecs[i].e_v0, vecs[i].e_d0, vecs[i].e_v1, vecs[i].e_d1, vecs[i].e_err);
            tick();
        end

        // ---- timeout: grant, no rvalid for 4 cycles, err pulse ----
        drive(1'b1, 16'h0044, 1'b0, 32'h0, 4'hF, 1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
        #2;
        check_all("to_gnt", 1'b1, 16'h0044, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0,
                  1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        for (int c = 1; c <= 4; c++) begin
            drive_idle(1'b0, 32'h0);
            #2;
            check_zero($sformatf("to_wait%0d", c), 1'b0);
            tick();
        end
        // err pulses now; the arbiter is idle again, so a late rvalid is dropped
        // and a new request is presented at once.
        drive(1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b1, 16'h0048, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1, 32'hAAAAAAAA);
        #2;
        check_all("to_err", 1'b1, 16'h0048, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0,
                  1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick();
        drive(1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b1, 16'h0048, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0);
        #2;
        check_all("to_next_gnt", 1'b1, 16'h0048, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1,
                  1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();

        // ---- rvalid in the last allowed cycle beats the timeout ----
        for (int c = 1; c <= 3; c++) begin
            drive_idle(1'b0, 32'h0);
            #2;
            check_zero($sformatf("edge_wait%0d", c), 1'b0);
            tick();
        end
        drive_idle(1'b1, 32'h5A5A5A5A);
        #2;
        check_all("edge_rv", 1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0,
                  1'b0, 32'h0, 1'b1, 32'h5A5A5A5A, 1'b0);
        tick();
        drive_idle(1'b0, 32'h0);
        #2;
        check_zero("edge_no_err", 1'b0);
        tick();

        // ---- reset while waiting for rvalid ----
        drive(1'b1, 16'h0080, 1'b0, 32'h0, 4'hF, 1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
        #2;
        check_all("rst_gnt", 1'b1, 16'h0080, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0,
                  1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b1, 16'h00A0, 1'b0, 32'h0, 4'hF, 1'b1, 16'h0090, 1'b0, 32'h0, 4'hF,
              1'b1, 1'b1, 32'hFFFFFFFF);
        rst_n = 1'b0;
        #1;
        check_zero("rst_async", 1'b0);
        tick();
        #1;
        check_zero("rst_held", 1'b0);
        // Release reset with a late rvalid: it must be dropped.
        rst_n = 1'b1;
        drive_idle(1'b1, 32'h11223344);
        #1;
        check_zero("rst_late_rv", 1'b0);
        tick();
        // Pointer is back on p0, so p0 wins a simultaneous request.
        drive(1'b1, 16'h00A0, 1'b0, 32'h0, 4'hF, 1'b1, 16'h0090, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0);
        #2;
        check_all("rst_regnt0", 1'b1, 16'h00A0, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0,
                  1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b1, 16'h0090, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1, 32'h55667788);
        #2;
        check_all("rst_rv0", 1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0,
                  1'b1, 32'h55667788, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b1, 16'h0090, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0);
        #2;
        check_all("rst_regnt1", 1'b1, 16'h0090, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1,
                  1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        drive_idle(1'b1, 32'h99AABBCC);
        #2;
        check_all("rst_rv1", 1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0,
                  1'b0, 32'h0, 1'b1, 32'h99AABBCC, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/core_mem_arbiter.md
CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, memory byte-address width.
REQ-002 Parameter DATA_WIDTH, default 32, data bus width.
REQ-003 Parameter BE_WIDTH, default 4, byte-enable width (DATA_WIDTH/8).
REQ-004 Parameter TIMEOUT, default 255, max cycles waiting for rvalid after grant; range 1..255.
REQ-005 Clock and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-006 Ports, one per line (N = 0 core data port, N = 1 loader/DMA port):
 clk  in  1  sole clock, rising edge
 rst_n  in  1  asynchronous active-low reset
 pN_req_i  in  1  requester N transaction request
 pN_addr_i  in  ADDR_WIDTH  requester N address
 pN_wr_i  in  1  requester N write (1) / read (0)
 pN_wdata_i  in  DATA_WIDTH  requester N write data
 pN_be_i  in  BE_WIDTH  requester N byte enables
 pN_gnt_o  out  1  grant pulse to requester N
 pN_rvalid_o  out  1  response pulse to requester N
 pN_rdata_o  out  DATA_WIDTH  read data to requester N
 mem_req_o  out  1  request to memory
 mem_addr_o  out  ADDR_WIDTH  memory address
 mem_wr_o  out  1  memory write strobe
 mem_wdata_o  out  DATA_WIDTH  memory write data
 mem_be_o  out  BE_WIDTH  memory byte enables
 mem_gnt_i  in  1  memory grant
 mem_rvalid_i  in  1  memory response valid (reads and writes)
 mem_rdata_i  in  DATA_WIDTH  memory read data
 err_o  out  1  one-cycle pulse on response timeout

Function
REQ-007 Protocol: requester holds req/addr/wr/wdata/be stable until its gnt; gnt is one cycle; exactly one rvalid per grant, 1+ cycles after gnt.
REQ-008 At most one outstanding memory transaction.
REQ-009 FSM states IDLE, REQ, WAIT_RV.
REQ-010 IDLE: if any pN_req_i high, select winner combinationally, assert mem_req_o with winner fields; mem_gnt_i same cycle -> WAIT_RV, else -> REQ with owner latched.
REQ-011 REQ: drive mem_req_o=1 with latched owner fields; owner fixed until mem_gnt_i; then -> WAIT_RV.
REQ-012 WAIT_RV: mem_req_o=0; on mem_rvalid_i -> IDLE; no new request presented in the rvalid cycle.
REQ-013 pN_gnt_o = mem_gnt_i AND mem_req_o AND (selected owner == N); never both high.
REQ-014 pN_rvalid_o = mem_rvalid_i AND state WAIT_RV AND owner == N; pN_rdata_o = mem_rdata_i when own rvalid, else 0.
REQ-015 mem_rvalid_i outside WAIT_RV is ignored (no rvalid routed, no state change).
REQ-016 Arbitration round-robin: priority pointer toggles to the non-granted port on each mem_gnt_i; single requester always wins.
REQ-017 When mem_req_o=0, mem_addr_o, mem_wr_o, mem_wdata_o, mem_be_o are 0.
REQ-018 Timeout counter (8 bit): cleared on entry to WAIT_RV, increments each WAIT_RV cycle without rvalid; on reaching TIMEOUT, err_o pulses one cycle, -> IDLE, no rvalid issued.
REQ-019 rvalid and timeout in same cycle: rvalid wins, no err_o.
REQ-020 Requester dropping req in REQ state is a protocol violation; arbiter keeps presenting latched owner (no recovery required).

Reset
REQ-021 rst_n low asynchronously: state IDLE, owner 0, priority pointer to port 0, timeout counter 0, err_o 0; all outputs 0 while in reset.
REQ-022 Reset during REQ or WAIT_RV abandons the transaction; a late mem_rvalid_i after reset is ignored per REQ-015.

Verification
REQ-023 p0 read 0x0040, mem_gnt_i same cycle, rvalid 2 cycles later data 0xDEADBEEF -> p0_gnt_o pulse, p0_rvalid_o with p0_rdata_o=0xDEADBEEF, p1 outputs 0.
REQ-024 p0 and p1 request same cycle from reset -> p0 granted first, p1 granted after p0 rvalid (earliest cycle after), pointer then favors p0.
REQ-025 p1 write 0x0100 data 0x12345678 be 0xF, mem_gnt_i delayed 3 cycles -> mem_req_o held 4 cycles with stable fields, single p1_gnt_o pulse.
REQ-026 Grant then no rvalid, TIMEOUT=4 -> err_o pulse 4 cycles after entering WAIT_RV, FSM IDLE, no pN_rvalid_o.
REQ-027 rst_n asserted in WAIT_RV, then mem_rvalid_i -> all outputs 0, no rvalid routed, next request granted normally.
REQ-028 mem_rvalid_i pulse while IDLE -> no pN_rvalid_o, state unchanged.
